popcnt_frame_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit one-hot population-count unit between two requesters. Each grant covers a frame of FRAME_LEN 4-bit words. Every accepted word passes through the shared counter, and the per-frame total of set bits is accumulated. The total is returned with the requester ID over a valid/ready result port. The block sits between the I/O-facing word sources and the population-count datapath, and is the only user of that datapath.

---
 rtl/popcnt_pkg.sv | 23 ++
 rtl/popcnt4_onehot.sv | 16 +
 rtl/popcnt_frame_sched.sv | 93 +++++++++
 tb/tb_popcnt_frame_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcnt_pkg.sv
// rtl/popcnt_pkg.sv - shared state type, widths and one-hot decode for the popcount frame scheduler
package popcnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ONEHOT_W = 5;

    // Line i of the one-hot count means "i bits set"; anything malformed decodes to 0.
    function automatic logic [2:0] onehot5_to_bin(input logic [ONEHOT_W-1:0] oh);
        case (oh)
            5'b00010: return 3'd1;
            5'b00100: return 3'd2;
            5'b01000: return 3'd3;
            5'b10000: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/popcnt4_onehot.sv
// rtl/popcnt4_onehot.sv - combinational 4-bit population count with one-hot output
module popcnt4_onehot
    import popcnt_pkg::*;
(
    input  logic [3:0]          word,
    output logic [ONEHOT_W-1:0] count_onehot
);

    logic [2:0] ones;

    always_comb begin
        ones         = 3'(word[0]) + 3'(word[1]) + 3'(word[2]) + 3'(word[3]);
        count_onehot = ONEHOT_W'(1) << ones;
    end

endmodule

// File: rtl/popcnt_frame_sched.sv
// rtl/popcnt_frame_sched.sv - round-robin frame scheduler sharing one popcount unit between two requesters
module popcnt_frame_sched
    import popcnt_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [ACC_W-1:0] res_count,
    output logic             busy
);

    localparam int               CNT_W     = 7;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);

    state_e               state;
    logic                 grant;
    logic                 prio;
    logic [CNT_W-1:0]     word_cnt;
    logic [ACC_W-1:0]     acc;
    logic [3:0]           sel_data;
    logic                 sel_valid;
    logic                 accept;
    logic [ONEHOT_W-1:0]  count_onehot;
    logic [2:0]           word_ones;

    assign sel_data  = grant ? req1_data  : req0_data;
    assign sel_valid = grant ? req1_valid : req0_valid;
    assign accept    = (state == RUN) && sel_valid;
    assign word_ones = onehot5_to_bin(count_onehot);

    popcnt4_onehot u_popcnt (
        .word         (sel_data),
        .count_onehot (count_onehot)
    );

    // Readies come only from registered state so they never follow valid combinationally.
    assign req0_ready = (state == RUN) && !grant;
    assign req1_ready = (state == RUN) && grant;
    assign res_valid  = (state == DONE);
    assign res_id     = grant;
    assign res_count  = acc;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            prio     <= 1'b0;
            word_cnt <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc      <= '0;
                    word_cnt <= '0;
                    if (req0_valid || req1_valid) begin
                        grant <= (req0_valid && req1_valid) ? prio : req1_valid;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc      <= acc + ACC_W'(word_ones);
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (word_cnt == LAST_WORD) begin
                            state <= DONE;
                            prio  <= ~grant;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcnt_frame_sched.sv
// tb/tb_popcnt_frame_sched.sv - scoreboard bench for popcnt_frame_sched with a frame-level reference model
module tb_popcnt_frame_sched;
    import popcnt_pkg::*;

    localparam int FL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_data, req1_data;
    logic       res_valid, res_ready, res_id, busy;
    logic [8:0] res_count;

    logic       a_valid, a_ready, a_r1_ready, a_res_valid, a_res_id, a_busy;
    logic [3:0] a_data;
    logic [8:0] a_res_count;
    logic       b_valid, b_ready, b_r1_ready, b_res_valid, b_res_id, b_busy;
    logic [3:0] b_data;
    logic [8:0] b_res_count;
    logic       side_zero_valid, side_res_ready;
    logic [3:0] side_zero_data;

    logic [3:0]          pc_word;
    logic [ONEHOT_W-1:0] pc_oh;

    popcnt_frame_sched #(.FRAME_LEN(FL), .ACC_W(9)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .busy(busy)
    );

    popcnt_frame_sched #(.FRAME_LEN(64), .ACC_W(9)) dut64 (
        .clk(clk), .rst(rst),
        .req0_valid(a_valid), .req0_data(a_data), .req0_ready(a_ready),
        .req1_valid(side_zero_valid), .req1_data(side_zero_data), .req1_ready(a_r1_ready),
        .res_valid(a_res_valid), .res_ready(side_res_ready), .res_id(a_res_id),
        .res_count(a_res_count), .busy(a_busy)
    );

    popcnt_frame_sched #(.FRAME_LEN(1), .ACC_W(9)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(b_valid), .req0_data(b_data), .req0_ready(b_ready),
        .req1_valid(side_zero_valid), .req1_data(side_zero_data), .req1_ready(b_r1_ready),
        .res_valid(b_res_valid), .res_ready(side_res_ready), .res_id(b_res_id),
        .res_count(b_res_count), .busy(b_busy)
    );

    popcnt4_onehot u_pc (.word(pc_word), .count_onehot(pc_oh));

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] q0[$], q1[$];
    int         g0[$], g1[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         model_prio = 0;
    int         bp_left    = 0;
    bit         rand_rr    = 1'b0;
    int         cyc        = 0;
    int         last_fire  = -10;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queues one frame of words for requester r; gap values hold valid low before that word.
    task automatic push_frame(input int r, input logic [3:0] w [FL], input int gap_at,
                              input int gap_len, input bit rgaps, output int sum);
        int g;
        sum = 0;
        for (int i = 0; i < FL; i++) begin
            g = (i == gap_at) ? gap_len : ((rgaps && i > 0) ? int'($urandom_range(0, 2)) : 0);
            sum += $countones(w[i]);
            if (r == 0) begin
                q0.push_back(w[i]);
                g0.push_back(g);
            end else begin
                q1.push_back(w[i]);
                g1.push_back(g);
            end
        end
    endtask

    task automatic expect_res(input int r, input int sum);
        exp_t e;
        e.id  = r;
        e.cnt = sum;
        exp_q.push_back(e);
        model_prio = 1 - r;
    endtask

    task automatic expect_pair(input int s0, input int s1);
        if (model_prio == 0) begin
            expect_res(0, s0);
            expect_res(1, s1);
        end else begin
            expect_res(1, s1);
            expect_res(0, s0);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, int'(n < budget), 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req0_ready"}, req0_ready, 0);
        check({name, "_req1_ready"}, req1_ready, 0);
        check({name, "_res_valid"},  res_valid,  0);
        check({name, "_res_id"},     res_id,     0);
        check({name, "_res_count"},  res_count,  0);
        check({name, "_busy"},       busy,       0);
    endtask

    initial begin : driver
        bit f0, f1;
        req0_valid = 1'b0; req0_data = 4'h0;
        req1_valid = 1'b0; req1_data = 4'h0;
        forever begin
            @(negedge clk);
            f0 = req0_valid && req0_ready;
            f1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (f0 && q0.size() != 0) begin q0.delete(0); g0.delete(0); end
            if (f1 && q1.size() != 0) begin q1.delete(0); g1.delete(0); end
            if (q0.size() == 0) req0_valid = 1'b0;
            else if (g0[0] > 0) begin g0[0] = g0[0] - 1; req0_valid = 1'b0; end
            else begin req0_valid = 1'b1; req0_data = q0[0]; end
            if (q1.size() == 0) req1_valid = 1'b0;
            else if (g1[0] > 0) begin g1[0] = g1[0] - 1; req1_valid = 1'b0; end
            else begin req1_valid = 1'b1; req1_data = q1[0]; end
        end
    end

    initial begin : monitor
        bit   prev_hold;
        int   cap_id, cap_cnt;
        exp_t e;
        prev_hold = 1'b0; cap_id = 0; cap_cnt = 0;
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) last_fire = cyc;
                if (req0_ready || req1_ready) check("ready_exclusive", int'(req0_ready && req1_ready), 0);
                if (res_valid) begin
                    if (!prev_hold) begin
                        check("result_latency", cyc - last_fire, 1);
                        cap_id  = res_id;
                        cap_cnt = res_count;
                    end else begin
                        check("res_id_stable", res_id, cap_id);
                        check("res_count_stable", res_count, cap_cnt);
                    end
                    if (res_ready) begin
                        check("result_expected", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("res_id", res_id, e.id);
                            check("res_count", res_count, e.cnt);
                        end
                    end else if (bp_left > 0) begin
                        bp_left--;
                    end
                end
                prev_hold = res_valid && !res_ready;
            end
            @(posedge clk);
            #1;
            res_ready = (bp_left > 0) ? 1'b0 : (rand_rr ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1);
    end

    initial begin : main
        logic [3:0] wa [FL];
        logic [3:0] wb [FL];
        logic [3:0] w1;
        int         s0, s1, n, guard;

        rst = 1'b1;
        a_valid = 1'b0; a_data = 4'h0;
        b_valid = 1'b0; b_data = 4'h0;
        side_zero_valid = 1'b0; side_zero_data = 4'h0; side_res_ready = 1'b1;
        pc_word = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Both requesters valid straight out of reset, all-ones frames.
        for (int i = 0; i < FL; i++) begin wa[i] = 4'hF; wb[i] = 4'hF; end
        push_frame(0, wa, -1, 0, 1'b0, s0);
        push_frame(1, wb, -1, 0, 1'b0, s1);
        expect_res(0, s0);
        expect_res(1, s1);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("both_from_reset", 200);

        wa = '{4'hF, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h8, 4'h6};
        push_frame(0, wa, -1, 0, 1'b0, s0);
        expect_res(0, s0);
        wait_idle("single_req0", 100);

        // req1 stalls 3 cycles before its 5th word, consumer back-pressures 5 cycles.
        for (int i = 0; i < FL; i++) wb[i] = 4'($urandom);
        bp_left = 5;
        push_frame(1, wb, 4, 3, 1'b0, s1);
        expect_res(1, s1);
        wait_idle("stall_backpressure", 200);

        for (int i = 0; i < FL; i++) wa[i] = 4'h0;
        push_frame(0, wa, -1, 0, 1'b0, s0);
        expect_res(0, s0);
        wait_idle("all_zero", 100);

        rand_rr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < FL; i++) begin wa[i] = 4'($urandom); wb[i] = 4'($urandom); end
            push_frame(0, wa, -1, 0, 1'b1, s0);
            push_frame(1, wb, -1, 0, 1'b1, s1);
            expect_pair(s0, s1);
            wait_idle("random_pair", 400);
        end
        rand_rr = 1'b0;

        // Complete one req0 frame so prio points at req1, then abort the next req0 frame.
        for (int i = 0; i < FL; i++) wa[i] = 4'($urandom);
        push_frame(0, wa, -1, 0, 1'b0, s0);
        expect_res(0, s0);
        wait_idle("pre_reset_frame", 100);
        for (int i = 0; i < FL; i++) wa[i] = 4'hF;
        push_frame(0, wa, -1, 0, 1'b0, s0);
        n = 0; guard = 0;
        while (n < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (req0_valid && req0_ready) n++;
        end
        check("reach_4th_accept", n, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        q0 = {}; g0 = {}; q1 = {}; g1 = {};
        model_prio = 0;
        for (int i = 0; i < FL; i++) begin wa[i] = 4'($urandom); wb[i] = 4'($urandom); end
        push_frame(0, wa, -1, 0, 1'b0, s0);
        push_frame(1, wb, -1, 0, 1'b0, s1);
        expect_pair(s0, s1);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("post_reset", 200);

        // FRAME_LEN = 1 instance.
        w1 = 4'h5;
        @(negedge clk);
        b_valid = 1'b1; b_data = w1;
        n = 0; guard = 0;
        while (n == 0 && guard < 10) begin
            @(negedge clk);
            guard++;
            if (b_valid && b_ready) n = 1;
        end
        check("fl1_accept", n, 1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        @(negedge clk);
        check("fl1_res_valid", b_res_valid, 1);
        check("fl1_res_id", b_res_id, 0);
        check("fl1_res_count", b_res_count, $countones(w1));

        // FRAME_LEN = 64 instance, all-ones words.
        w1 = 4'hF;
        @(negedge clk);
        a_valid = 1'b1; a_data = w1;
        n = 0; guard = 0;
        while (n < 64 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (a_valid && a_ready) n++;
        end
        check("fl64_accepts", n, 64);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        check("fl64_res_valid", a_res_valid, 1);
        check("fl64_res_count", a_res_count, 64 * $countones(w1));

        for (int w = 0; w < 16; w++) begin
            pc_word = 4'(w);
            #1;
            check("onehot_lines", $countones(pc_oh), 1);
            check("onehot_weight", int'(onehot5_to_bin(pc_oh)), $countones(pc_word));
            check("onehot_line_pos", int'(pc_oh[$countones(pc_word)]), 1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
